// File: rtl/ks_note_sequencer.sv
// Pattern-memory step sequencer feeding period/pluck to the Karplus-Strong string.
// Each step loads a period, gates pluck for GATE_TICKS ticks, then holds until tempo expires.
module ks_note_sequencer #(
  parameter int NUM_STEPS      = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int TEMPO_WIDTH    = 16,
  parameter int GATE_TICKS     = 4,
  parameter int DEFAULT_PERIOD = 40
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         enable_i,
  input  logic                         loop_en_i,
  input  logic [$clog2(NUM_STEPS)-1:0] length_i,
  input  logic [TEMPO_WIDTH-1:0]       tempo_i,
  input  logic                         step_tick_i,
  input  logic                         wr_en_i,
  input  logic [$clog2(NUM_STEPS)-1:0] wr_addr_i,
  input  logic [DATA_WIDTH:0]          wr_data_i,
  output logic [DATA_WIDTH-1:0]        period_o,
  output logic                         pluck_o,
  output logic [$clog2(NUM_STEPS)-1:0] step_o,
  output logic                         busy_o,
  output logic                         done_o
);

  localparam int AW = $clog2(NUM_STEPS);
  localparam int WW = DATA_WIDTH + 1;
  localparam logic [DATA_WIDTH-1:0]  DEF_PERIOD = DATA_WIDTH'(DEFAULT_PERIOD);
  localparam logic [WW-1:0]          DEF_WORD   = {1'b1, DEF_PERIOD};
  localparam logic [TEMPO_WIDTH-1:0] GATE_CNT   = TEMPO_WIDTH'(GATE_TICKS);
  localparam logic [TEMPO_WIDTH-1:0] TICK_ONE   = TEMPO_WIDTH'(1);
  localparam logic [TEMPO_WIDTH-1:0] TICK_ZERO  = {TEMPO_WIDTH{1'b0}};
  localparam logic [AW-1:0]          STEP_ONE   = AW'(1);
  localparam logic [AW-1:0]          STEP_ZERO  = {AW{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_PLUCK = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  logic [WW-1:0]          r_mem [NUM_STEPS];
  state_t                 r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0]  r_period, w_period_nxt;
  logic                   r_pluck, w_pluck_nxt;
  logic                   r_busy, w_busy_nxt;
  logic                   r_done, w_done_nxt;
  logic [AW-1:0]          r_step, w_step_nxt;
  logic [TEMPO_WIDTH-1:0] r_tick_cnt, w_tick_cnt_nxt;
  logic [TEMPO_WIDTH-1:0] r_tempo, w_tempo_nxt;
  logic [WW-1:0]          w_rd_word;
  logic                   w_step_end;

  // Read port sees the pre-write word when a write targets the step being loaded.
  assign w_rd_word  = r_mem[r_step];
  assign w_step_end = step_tick_i && (r_tick_cnt == r_tempo);

  // Pattern memory: {rest, period} per step, writable in every state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_STEPS; i++) begin
        r_mem[i] <= DEF_WORD;
      end
    end else if (wr_en_i) begin
      r_mem[wr_addr_i] <= wr_data_i;
    end
  end

  // Next-state and next-output logic for the step FSM.
  always_comb begin
    w_state_nxt    = r_state;
    w_period_nxt   = r_period;
    w_pluck_nxt    = r_pluck;
    w_step_nxt     = r_step;
    w_done_nxt     = 1'b0;
    w_tick_cnt_nxt = r_tick_cnt;
    w_tempo_nxt    = r_tempo;

    if ((r_state != ST_IDLE) && !enable_i) begin
      // Abort: drop the note, keep period and step for inspection.
      w_state_nxt = ST_IDLE;
      w_pluck_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_pluck_nxt = 1'b0;
          if (enable_i) begin
            w_step_nxt  = STEP_ZERO;
            w_state_nxt = ST_LOAD;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_LOAD: begin
          w_tempo_nxt    = tempo_i;
          w_tick_cnt_nxt = {{(TEMPO_WIDTH-1){1'b0}}, step_tick_i};
          if (!w_rd_word[DATA_WIDTH]) begin
            w_period_nxt = w_rd_word[DATA_WIDTH-1:0];
            w_pluck_nxt  = 1'b1;
            w_state_nxt  = ST_PLUCK;
          end else begin
            w_pluck_nxt  = 1'b0;
            w_state_nxt  = ST_HOLD;
          end
        end
        ST_PLUCK, ST_HOLD: begin
          if (w_step_end) begin
            w_pluck_nxt    = 1'b0;
            w_tick_cnt_nxt = TICK_ZERO;
            if (r_step != length_i) begin
              w_step_nxt  = r_step + STEP_ONE;
              w_state_nxt = ST_LOAD;
            end else if (loop_en_i) begin
              w_step_nxt  = STEP_ZERO;
              w_state_nxt = ST_LOAD;
            end else begin
              w_done_nxt  = 1'b1;
              w_state_nxt = ST_IDLE;
            end
          end else begin
            if (step_tick_i) begin
              w_tick_cnt_nxt = r_tick_cnt + TICK_ONE;
            end else begin
              w_tick_cnt_nxt = r_tick_cnt;
            end
            // Gate closes once the counter has reached GATE_TICKS.
            if ((r_state == ST_PLUCK) && (r_tick_cnt >= GATE_CNT)) begin
              w_pluck_nxt = 1'b0;
              w_state_nxt = ST_HOLD;
            end else begin
              w_state_nxt = r_state;
            end
          end
        end
        default: begin
          w_pluck_nxt = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      endcase
    end

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= ST_IDLE;
      r_period   <= DEF_PERIOD;
      r_pluck    <= 1'b0;
      r_step     <= STEP_ZERO;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_tick_cnt <= TICK_ZERO;
      r_tempo    <= TICK_ZERO;
    end else begin
      r_state    <= w_state_nxt;
      r_period   <= w_period_nxt;
      r_pluck    <= w_pluck_nxt;
      r_step     <= w_step_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_tick_cnt <= w_tick_cnt_nxt;
      r_tempo    <= w_tempo_nxt;
    end
  end

  assign period_o = r_period;
  assign pluck_o  = r_pluck;
  assign step_o   = r_step;
  assign busy_o   = r_busy;
  assign done_o   = r_done;

endmodule

// File: tb/tb_ks_note_sequencer.sv
// Directed bench for ks_note_sequencer: step_tick every 4 clocks, events logged per edge.
module tb_ks_note_sequencer;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       enable_i;
  logic       loop_en_i;
  logic [2:0] length_i;
  logic [15:0] tempo_i;
  logic       step_tick_i;
  logic       wr_en_i;
  logic [2:0] wr_addr_i;
  logic [8:0] wr_data_i;
  logic [7:0] period_o;
  logic       pluck_o;
  logic [2:0] step_o;
  logic       busy_o;
  logic       done_o;

  int checks   = 0;
  int failures = 0;

  int cyc_idx;
  int tick_div;
  int pluck_ticks;
  int done_cnt;
  int done_at;
  int wr_at = -1;
  logic [2:0] wr_adr;
  logic [8:0] wr_word;
  int rise_per[$];
  int rise_at[$];
  int step_seq[$];
  int step_at[$];

  ks_note_sequencer dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .enable_i   (enable_i),
    .loop_en_i  (loop_en_i),
    .length_i   (length_i),
    .tempo_i    (tempo_i),
    .step_tick_i(step_tick_i),
    .wr_en_i    (wr_en_i),
    .wr_addr_i  (wr_addr_i),
    .wr_data_i  (wr_data_i),
    .period_o   (period_o),
    .pluck_o    (pluck_o),
    .step_o     (step_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic write_mem(input logic [2:0] a, input logic [8:0] d);
    @(negedge clk_i);
    wr_en_i   = 1'b1;
    wr_addr_i = a;
    wr_data_i = d;
    @(posedge clk_i);
    #1;
    wr_en_i = 1'b0;
  endtask

  // Edge 0 of the run is the IDLE->LOAD edge and carries a tick.
  task automatic start();
    cyc_idx     = 0;
    tick_div    = 0;
    pluck_ticks = 0;
    done_cnt    = 0;
    done_at     = -1;
    rise_per.delete();
    rise_at.delete();
    step_seq.delete();
    step_at.delete();
    enable_i = 1'b1;
  endtask

  task automatic run(input int n);
    logic       prev_pluck;
    logic [2:0] prev_step;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      prev_pluck  = pluck_o;
      prev_step   = step_o;
      step_tick_i = (tick_div == 0);
      tick_div    = (tick_div + 1) % 4;
      if (cyc_idx == wr_at) begin
        wr_en_i   = 1'b1;
        wr_addr_i = wr_adr;
        wr_data_i = wr_word;
      end else begin
        wr_en_i = 1'b0;
      end
      @(posedge clk_i);
      #1;
      if (step_tick_i && prev_pluck) pluck_ticks++;
      if (done_o) begin
        done_cnt++;
        done_at = cyc_idx;
      end
      if (pluck_o && !prev_pluck) begin
        rise_per.push_back(int'(period_o));
        rise_at.push_back(cyc_idx);
      end
      if (step_o != prev_step) begin
        step_seq.push_back(int'(step_o));
        step_at.push_back(cyc_idx);
      end
      cyc_idx++;
    end
    step_tick_i = 1'b0;
    wr_en_i     = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    enable_i = 1'b0; loop_en_i = 1'b0; length_i = 3'd0; tempo_i = 16'd0;
    step_tick_i = 1'b0; wr_en_i = 1'b0; wr_addr_i = 3'd0; wr_data_i = 9'd0;
    repeat (3) @(posedge clk_i);
    #1;
    checks++;
    if (period_o !== 8'd40) begin failures++; $display("FAIL reset_period: got %0d expected 40", period_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    checks++;
    if (period_o !== 8'd40) begin failures++; $display("FAIL idle_period: got %0d expected 40", period_o); end
    checks++;
    if (pluck_o !== 1'b0) begin failures++; $display("FAIL idle_pluck: got %0b expected 0", pluck_o); end
    checks++;
    if (busy_o !== 1'b0) begin failures++; $display("FAIL idle_busy: got %0b expected 0", busy_o); end
    checks++;
    if (step_o !== 3'd0) begin failures++; $display("FAIL idle_step: got %0d expected 0", step_o); end
    checks++;
    if (done_o !== 1'b0) begin failures++; $display("FAIL idle_done: got %0b expected 0", done_o); end
  endtask

  task automatic test_all_rest();
    length_i = 3'd1; tempo_i = 16'd2; loop_en_i = 1'b0;
    start();
    run(5);
    checks++;
    if (busy_o !== 1'b1) begin failures++; $display("FAIL rest_busy_run: got %0b expected 1", busy_o); end
    run(20);
    enable_i = 1'b0;
    checks++;
    if (done_at !== 24) begin failures++; $display("FAIL rest_done_at: got %0d expected 24", done_at); end
    checks++;
    if (rise_per.size() !== 0) begin failures++; $display("FAIL rest_no_pluck: got %0d rises expected 0", rise_per.size()); end
    checks++;
    if (period_o !== 8'd40) begin failures++; $display("FAIL rest_period: got %0d expected 40", period_o); end
    checks++;
    if (step_o !== 3'd1) begin failures++; $display("FAIL rest_step: got %0d expected 1", step_o); end
    run(2);
    checks++;
    if (done_cnt !== 1) begin failures++; $display("FAIL rest_done_count: got %0d expected 1", done_cnt); end
    checks++;
    if (busy_o !== 1'b0) begin failures++; $display("FAIL rest_busy_end: got %0b expected 0", busy_o); end
  endtask

  task automatic test_single_pass();
    write_mem(3'd0, {1'b0, 8'd20});
    write_mem(3'd1, {1'b0, 8'd33});
    length_i = 3'd1; tempo_i = 16'd7; loop_en_i = 1'b0;
    start();
    run(65);
    enable_i = 1'b0;
    checks++;
    if (rise_per.size() !== 2) begin failures++; $display("FAIL pass_rise_count: got %0d expected 2", rise_per.size()); end
    checks++;
    if ((rise_per.size() > 0 ? rise_per[0] : -1) !== 20) begin failures++; $display("FAIL pass_period0: got %0d expected 20", (rise_per.size() > 0 ? rise_per[0] : -1)); end
    checks++;
    if ((rise_per.size() > 1 ? rise_per[1] : -1) !== 33) begin failures++; $display("FAIL pass_period1: got %0d expected 33", (rise_per.size() > 1 ? rise_per[1] : -1)); end
    checks++;
    if (pluck_ticks !== 8) begin failures++; $display("FAIL pass_pluck_ticks: got %0d expected 8", pluck_ticks); end
    checks++;
    if ((step_at.size() > 1 ? step_at[1] : -1) !== 32) begin failures++; $display("FAIL pass_step_len: got %0d expected 32", (step_at.size() > 1 ? step_at[1] : -1)); end
    checks++;
    if (done_at !== 64) begin failures++; $display("FAIL pass_done_at: got %0d expected 64", done_at); end
    run(2);
    checks++;
    if (done_cnt !== 1) begin failures++; $display("FAIL pass_done_count: got %0d expected 1", done_cnt); end
    checks++;
    if (busy_o !== 1'b0) begin failures++; $display("FAIL pass_busy_end: got %0b expected 0", busy_o); end
    checks++;
    if (period_o !== 8'd33) begin failures++; $display("FAIL pass_period_end: got %0d expected 33", period_o); end
  endtask

  task automatic test_loop();
    int exp_per[5];
    int exp_at[5];
    int exp_stp[5];
    int got;
    exp_per = '{20, 33, 20, 33, 20};
    exp_at  = '{1, 33, 65, 97, 129};
    exp_stp = '{0, 1, 0, 1, 0};
    length_i = 3'd1; tempo_i = 16'd7; loop_en_i = 1'b1;
    start();
    run(130);
    for (int i = 0; i < 5; i++) begin
      got = (i < rise_per.size()) ? rise_per[i] : -1;
      checks++;
      if (got !== exp_per[i]) begin failures++; $display("FAIL loop_period[%0d]: got %0d expected %0d", i, got, exp_per[i]); end
      got = (i < rise_at.size()) ? rise_at[i] : -1;
      checks++;
      if (got !== exp_at[i]) begin failures++; $display("FAIL loop_rise_at[%0d]: got %0d expected %0d", i, got, exp_at[i]); end
      got = (i < step_seq.size()) ? step_seq[i] : -1;
      checks++;
      if (got !== exp_stp[i]) begin failures++; $display("FAIL loop_step[%0d]: got %0d expected %0d", i, got, exp_stp[i]); end
    end
    checks++;
    if (done_cnt !== 0) begin failures++; $display("FAIL loop_no_done: got %0d expected 0", done_cnt); end
    checks++;
    if (pluck_ticks !== 16) begin failures++; $display("FAIL loop_pluck_ticks: got %0d expected 16", pluck_ticks); end
    enable_i = 1'b0;
    run(1);
    checks++;
    if (busy_o !== 1'b0) begin failures++; $display("FAIL loop_abort_busy: got %0b expected 0", busy_o); end
  endtask

  task automatic test_short_tempo();
    length_i = 3'd1; tempo_i = 16'd1; loop_en_i = 1'b0;
    start();
    run(17);
    enable_i = 1'b0;
    checks++;
    if (pluck_ticks !== 4) begin failures++; $display("FAIL short_pluck_ticks: got %0d expected 4", pluck_ticks); end
    checks++;
    if ((rise_at.size() > 1 ? rise_at[1] : -1) !== 9) begin failures++; $display("FAIL short_rise1_at: got %0d expected 9", (rise_at.size() > 1 ? rise_at[1] : -1)); end
    checks++;
    if (done_at !== 16) begin failures++; $display("FAIL short_done_at: got %0d expected 16", done_at); end
    run(2);
  endtask

  task automatic test_abort();
    length_i = 3'd1; tempo_i = 16'd7; loop_en_i = 1'b0;
    start();
    run(40);
    checks++;
    if ((pluck_o !== 1'b1) || (step_o !== 3'd1)) begin failures++; $display("FAIL abort_pre: got pluck=%0b step=%0d expected pluck=1 step=1", pluck_o, step_o); end
    enable_i = 1'b0;
    run(1);
    checks++;
    if (pluck_o !== 1'b0) begin failures++; $display("FAIL abort_pluck: got %0b expected 0", pluck_o); end
    checks++;
    if (busy_o !== 1'b0) begin failures++; $display("FAIL abort_busy: got %0b expected 0", busy_o); end
    checks++;
    if (period_o !== 8'd33) begin failures++; $display("FAIL abort_period: got %0d expected 33", period_o); end
    run(4);
    checks++;
    if (done_cnt !== 0) begin failures++; $display("FAIL abort_no_done: got %0d expected 0", done_cnt); end
    start();
    run(2);
    checks++;
    if (step_o !== 3'd0) begin failures++; $display("FAIL reenable_step: got %0d expected 0", step_o); end
    checks++;
    if ((period_o !== 8'd20) || (pluck_o !== 1'b1)) begin failures++; $display("FAIL reenable_note: got period=%0d pluck=%0b expected period=20 pluck=1", period_o, pluck_o); end
    enable_i = 1'b0;
    run(2);
  endtask

  task automatic test_write_during_load();
    int exp_per[4];
    int got;
    exp_per = '{20, 33, 20, 50};
    length_i = 3'd1; tempo_i = 16'd7; loop_en_i = 1'b1;
    start();
    wr_at   = 33;
    wr_adr  = 3'd1;
    wr_word = {1'b0, 8'd50};
    run(100);
    wr_at = -1;
    for (int i = 0; i < 4; i++) begin
      got = (i < rise_per.size()) ? rise_per[i] : -1;
      checks++;
      if (got !== exp_per[i]) begin failures++; $display("FAIL wr_load_period[%0d]: got %0d expected %0d", i, got, exp_per[i]); end
    end
    enable_i = 1'b0;
    run(1);
  endtask

  task automatic test_full_length_wrap();
    int got;
    length_i = 3'd7; tempo_i = 16'd1; loop_en_i = 1'b1;
    start();
    run(70);
    checks++;
    if (step_seq.size() !== 9) begin failures++; $display("FAIL wrap_step_count: got %0d expected 9", step_seq.size()); end
    for (int i = 0; i < 9; i++) begin
      got = (i < step_seq.size()) ? step_seq[i] : -1;
      checks++;
      if (got !== (i % 8)) begin failures++; $display("FAIL wrap_step[%0d]: got %0d expected %0d", i, got, i % 8); end
      got = (i < step_at.size()) ? step_at[i] : -1;
      checks++;
      if (got !== 8 * i) begin failures++; $display("FAIL wrap_step_at[%0d]: got %0d expected %0d", i, got, 8 * i); end
    end
    checks++;
    if (rise_per.size() !== 3) begin failures++; $display("FAIL wrap_rise_count: got %0d expected 3", rise_per.size()); end
    checks++;
    if ((rise_per.size() > 1 ? rise_per[1] : -1) !== 50) begin failures++; $display("FAIL wrap_period1: got %0d expected 50", (rise_per.size() > 1 ? rise_per[1] : -1)); end
    checks++;
    if (done_cnt !== 0) begin failures++; $display("FAIL wrap_no_done: got %0d expected 0", done_cnt); end
    enable_i = 1'b0;
    run(2);
  endtask

  initial begin
    test_reset();
    test_all_rest();
    test_single_pass();
    test_loop();
    test_short_tempo();
    test_abort();
    test_write_during_load();
    test_full_length_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
